// File: rtl/frame_pkg.sv
// Shared frame geometry and FAS definition for the mapper, demapper and aligner.
// Contents:
//   FRAME_ROWS, FRAME_COLS   frame geometry (4 x 1041)
//   FAS_PATTERN, FAS_LEN     6-byte frame alignment signal, MSB byte sent first at (0,0)
//   FAS_CHECK_COL            column of the last FAS byte, where the FAS is checked
//   OOF_THRESH               consecutive bad FAS checks in SYNC before returning to HUNT
//   state_e                  aligner FSM states
package frame_pkg;

    localparam int unsigned FRAME_ROWS    = 4;
    localparam int unsigned FRAME_COLS    = 1041;
    localparam int unsigned FAS_LEN       = 6;
    localparam int unsigned FAS_CHECK_COL = 5;
    localparam int unsigned OOF_THRESH    = 5;

    localparam logic [FAS_LEN*8-1:0] FAS_PATTERN = 48'hF6F6F6282828;

    localparam int unsigned ROW_W  = 2;
    localparam int unsigned COL_W  = 11;
    localparam int unsigned MISS_W = 3;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FRAME_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(FRAME_COLS - 1);
    localparam logic [COL_W-1:0]  CHECK_COL = COL_W'(FAS_CHECK_COL);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(OOF_THRESH - 1);

    typedef enum logic [1:0] {
        StHunt,
        StPresync,
        StSync
    } state_e;

endpackage

// File: rtl/fas_detector.sv
// FAS detector: 48-bit shift register of received words plus a comparator.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_data         received word
//   i_valid        word qualifier; the shift register only advances on valid words
//   o_match        combinational: the last five stored words plus the current word form the FAS
module fas_detector
    import frame_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_match
);

    logic [FAS_LEN*8-1:0] shreg_q, shreg_d;

    // The current word is included so the match lines up with the word at the check column.
    assign shreg_d = {shreg_q[FAS_LEN*8-9:0], i_data};
    assign o_match = i_valid && (shreg_d == FAS_PATTERN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg_q <= '0;
        end else if (i_valid) begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/frame_aligner.sv
// Receive-side frame aligner: hunts for the FAS, confirms it, then tracks frame position.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_data/i_valid unaligned input word stream, no backpressure
//   o_data/o_valid input delayed by one register stage
//   o_row_cnt      row of the o_data word (0 in HUNT)
//   o_col_cnt      column of the o_data word (0 in HUNT)
//   o_sof          pulse when o_data is at (0,0) while in SYNC
//   o_in_frame     high while in SYNC
//   o_oof          high while in HUNT
module frame_aligner
    import frame_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic [ROW_W-1:0] o_row_cnt,
    output logic [COL_W-1:0] o_col_cnt,
    output logic             o_sof,
    output logic             o_in_frame,
    output logic             o_oof
);

    logic              match;
    state_e            state_q, state_d;
    // row_q/col_q hold the position of the next valid word while in PRESYNC/SYNC.
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              at_check;

    logic [7:0]        data_q;
    logic              valid_q;
    logic [ROW_W-1:0]  row_out_q;
    logic [COL_W-1:0]  col_out_q;
    logic              sof_q;
    logic              in_frame_q;
    logic              oof_q;

    fas_detector u_fas_detector (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_match (match)
    );

    assign at_check = (row_q == '0) && (col_q == CHECK_COL);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        miss_d  = miss_q;
        cur_row = row_q;
        cur_col = col_q;

        if (i_valid) begin
            if (state_q == StHunt) begin
                if (match) begin
                    // The matching word is the last FAS byte, i.e. (0,5).
                    state_d = StPresync;
                    cur_row = '0;
                    cur_col = CHECK_COL;
                    row_d   = '0;
                    col_d   = CHECK_COL + COL_W'(1);
                end
            end else begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end

                if (at_check) begin
                    if (state_q == StPresync) begin
                        state_d = match ? StSync : StHunt;
                    end else if (match) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_LAST) begin
                        state_d = StHunt;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end

                if (state_d == StHunt) begin
                    row_d = '0;
                    col_d = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StHunt;
            row_q   <= '0;
            col_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            miss_q  <= miss_d;
        end
    end

    // Output stage: status reflects the state after the current word has been processed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            row_out_q  <= '0;
            col_out_q  <= '0;
            sof_q      <= 1'b0;
            in_frame_q <= 1'b0;
            oof_q      <= 1'b1;
        end else begin
            data_q     <= i_data;
            valid_q    <= i_valid;
            in_frame_q <= (state_d == StSync);
            oof_q      <= (state_d == StHunt);
            sof_q      <= i_valid && (state_d == StSync) && (cur_row == '0) && (cur_col == '0);
            if (i_valid) begin
                row_out_q <= (state_d == StHunt) ? '0 : cur_row;
                col_out_q <= (state_d == StHunt) ? '0 : cur_col;
            end
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_row_cnt  = row_out_q;
    assign o_col_cnt  = col_out_q;
    assign o_sof      = sof_q;
    assign o_in_frame = in_frame_q;
    assign o_oof      = oof_q;

endmodule

// File: tb/tb_frame_aligner.sv
// Self-checking bench for frame_aligner: random payload frames checked word by word against a
// behavioural model that tracks the frame position as a linear offset into the 4164-word frame.
module tb_frame_aligner;

    localparam logic [47:0] FAS  = 48'hF6F6F6282828;
    localparam int          COLS = 1041;
    localparam int          FLEN = 4 * 1041;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_sof;
    logic        o_in_frame;
    logic        o_oof;

    int compared = 0;
    int failed   = 0;

    // Model state: 0 = hunt, 1 = presync, 2 = sync.
    int         m_state, m_pos, m_miss;
    logic [7:0] m_hist [0:4];
    logic       e_valid, e_sof, e_inf, e_oof;
    logic [7:0] e_data;
    int         e_row, e_col;

    // Stream generator: position in the transmitted frame, plus optional corruption/planting.
    int gen_idx = 0;
    int last_idx = 0;
    int corrupt_pos = -1;
    int plant_pos = -1;

    frame_aligner dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_row_cnt  (o_row_cnt),
        .o_col_cnt  (o_col_cnt),
        .o_sof      (o_sof),
        .o_in_frame (o_in_frame),
        .o_oof      (o_oof)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fas_byte(input int k);
        logic [47:0] p;
        p = FAS;
        return p[8*(5-k) +: 8];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_miss  = 0;
        for (int i = 0; i < 5; i++) m_hist[i] = '0;
        e_valid = 1'b0;
        e_data  = '0;
        e_row   = 0;
        e_col   = 0;
        e_sof   = 1'b0;
        e_inf   = 1'b0;
        e_oof   = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        int   cur;
        logic m;
        e_valid = v;
        e_data  = d;
        e_sof   = 1'b0;
        if (v) begin
            m = ({m_hist[0], m_hist[1], m_hist[2], m_hist[3], m_hist[4], d} == FAS);
            for (int i = 0; i < 4; i++) m_hist[i] = m_hist[i+1];
            m_hist[4] = d;
            cur = 0;
            if (m_state == 0) begin
                if (m) begin
                    m_state = 1;
                    cur     = 5;
                    m_pos   = 6;
                end
            end else begin
                cur   = m_pos;
                m_pos = (m_pos + 1) % FLEN;
                if (cur == 5) begin
                    if (m_state == 1) begin
                        m_state = m ? 2 : 0;
                    end else if (m) begin
                        m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == 5) begin
                            m_state = 0;
                            m_miss  = 0;
                        end
                    end
                end
            end
            if (m_state == 0) begin
                e_row = 0;
                e_col = 0;
            end else begin
                e_row = cur / COLS;
                e_col = cur % COLS;
            end
            e_sof = (m_state == 2) && (cur == 0);
        end
        e_inf = (m_state == 2);
        e_oof = (m_state == 0);
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        i_valid = v;
        i_data  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic get_byte(output logic [7:0] b);
        b = 8'($urandom);
        if (gen_idx < 6) b = fas_byte(gen_idx);
        if (plant_pos >= 0 && gen_idx >= plant_pos && gen_idx < plant_pos + 6)
            b = fas_byte(gen_idx - plant_pos);
        if (gen_idx == corrupt_pos) b = b ^ 8'h01;
        last_idx = gen_idx;
        gen_idx  = (gen_idx + 1) % FLEN;
    endtask

    task automatic send_gen(input logic v);
        logic [7:0] b;
        if (v) begin
            get_byte(b);
            send(1'b1, b);
        end else begin
            send(1'b0, 8'($urandom));
        end
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'($urandom);
        i_data  = 8'($urandom);
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({o_valid, o_data, o_row_cnt, o_col_cnt, o_sof, o_in_frame, o_oof} !== {1'b0, 8'h00,
            2'd0, 11'd0, 1'b0, 1'b0, 1'b1}) begin
            failed++;
            $display("FAIL reset_state: got v=%0b d=%h r=%0d c=%0d sof=%0b inf=%0b oof=%0b, need all 0 oof=1",
                     o_valid, o_data, o_row_cnt, o_col_cnt, o_sof, o_in_frame, o_oof);
        end
    endtask

    task automatic test_acquire();
        int sofs;
        for (int i = 0; i < 100; i++) begin
            send(1'b1, 8'($urandom));
            compared++;
            if (o_oof !== 1'b1 || o_in_frame !== 1'b0 || o_data !== e_data || o_valid !== 1'b1) begin
                failed++;
                $display("FAIL acq_hunt: got oof=%0b inf=%0b d=%h v=%0b need oof=1 inf=0 d=%h v=1",
                         o_oof, o_in_frame, o_data, o_valid, e_data);
            end
        end
        gen_idx = 0;
        for (int f = 0; f < 3; f++) begin
            sofs = 0;
            for (int i = 0; i < FLEN; i++) begin
                send_gen(1'b1);
                sofs += int'(o_sof);
                compared++;
                if (o_valid !== e_valid || o_data !== e_data || o_sof !== e_sof ||
                    o_in_frame !== e_inf || o_oof !== e_oof ||
                    o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col)) begin
                    failed++;
                    $display("FAIL acq_word f%0d i%0d: got r=%0d c=%0d sof=%0b inf=%0b oof=%0b need r=%0d c=%0d sof=%0b inf=%0b oof=%0b",
                             f, i, o_row_cnt, o_col_cnt, o_sof, o_in_frame, o_oof,
                             e_row, e_col, e_sof, e_inf, e_oof);
                end
                if (f == 0 && last_idx == 5) begin
                    compared++;
                    if (o_row_cnt !== 2'd0 || o_col_cnt !== 11'd5 || o_oof !== 1'b0 ||
                        o_in_frame !== 1'b0) begin
                        failed++;
                        $display("FAIL acq_presync: got r=%0d c=%0d oof=%0b inf=%0b need 0 5 0 0",
                                 o_row_cnt, o_col_cnt, o_oof, o_in_frame);
                    end
                end
                if (f == 1 && last_idx == 5) begin
                    compared++;
                    if (o_in_frame !== 1'b1) begin
                        failed++;
                        $display("FAIL acq_sync: got inf=%0b need 1", o_in_frame);
                    end
                end
            end
            compared++;
            if (sofs !== ((f == 2) ? 1 : 0)) begin
                failed++;
                $display("FAIL acq_sof_count f%0d: got %0d need %0d", f, sofs, (f == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_valid_gaps();
        for (int i = 0; i < FLEN; i++) begin
            send_gen(i % 2 == 0);
            compared++;
            if (o_valid !== e_valid || o_data !== e_data || o_sof !== e_sof ||
                o_in_frame !== e_inf || o_oof !== e_oof ||
                (e_valid && (o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col)))) begin
                failed++;
                $display("FAIL gap_word i%0d: got v=%0b r=%0d c=%0d sof=%0b need v=%0b r=%0d c=%0d sof=%0b",
                         i, o_valid, o_row_cnt, o_col_cnt, o_sof, e_valid, e_row, e_col, e_sof);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < FLEN; i++) begin
            send_gen(1'b1);
            compared++;
            if (o_valid !== e_valid || o_sof !== e_sof || o_in_frame !== e_inf ||
                o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col) || o_col_cnt > 11'd1040) begin
                failed++;
                $display("FAIL wrap_word i%0d: got r=%0d c=%0d sof=%0b need r=%0d c=%0d sof=%0b",
                         i, o_row_cnt, o_col_cnt, o_sof, e_row, e_col, e_sof);
            end
            if (last_idx == 4163 || last_idx == 0 || last_idx == 1040 || last_idx == 1041) begin
                compared++;
                if ({o_row_cnt, o_col_cnt, o_sof} !== {2'(last_idx / COLS), 11'(last_idx % COLS),
                    last_idx == 0}) begin
                    failed++;
                    $display("FAIL wrap_point idx%0d: got r=%0d c=%0d sof=%0b need r=%0d c=%0d",
                             last_idx, o_row_cnt, o_col_cnt, o_sof, last_idx / COLS,
                             last_idx % COLS);
                end
            end
        end
    endtask

    task automatic test_oof_thresh();
        while (gen_idx != 0) send_gen(1'b1);
        for (int f = 0; f < 10; f++) begin
            corrupt_pos = (f == 4) ? -1 : 0;
            for (int i = 0; i < FLEN; i++) begin
                send_gen(1'b1);
                compared++;
                if (o_valid !== e_valid || o_sof !== e_sof || o_in_frame !== e_inf ||
                    o_oof !== e_oof || o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col)) begin
                    failed++;
                    $display("FAIL oof_word f%0d i%0d: got r=%0d c=%0d inf=%0b oof=%0b need r=%0d c=%0d inf=%0b oof=%0b",
                             f, i, o_row_cnt, o_col_cnt, o_in_frame, o_oof,
                             e_row, e_col, e_inf, e_oof);
                end
                if (last_idx == 5) begin
                    compared++;
                    if (o_in_frame !== (f != 9) || o_oof !== (f == 9)) begin
                        failed++;
                        $display("FAIL oof_check f%0d: got inf=%0b oof=%0b need inf=%0b oof=%0b",
                                 f, o_in_frame, o_oof, f != 9, f == 9);
                    end
                end
            end
        end
        corrupt_pos = -1;
    endtask

    task automatic test_presync_fail();
        for (int f = 0; f < 4; f++) begin
            corrupt_pos = (f == 1) ? 2 : -1;
            for (int i = 0; i < FLEN; i++) begin
                send_gen(1'b1);
                compared++;
                if (o_valid !== e_valid || o_sof !== e_sof || o_in_frame !== e_inf ||
                    o_oof !== e_oof || o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col)) begin
                    failed++;
                    $display("FAIL pre_word f%0d i%0d: got r=%0d c=%0d inf=%0b oof=%0b need r=%0d c=%0d inf=%0b oof=%0b",
                             f, i, o_row_cnt, o_col_cnt, o_in_frame, o_oof,
                             e_row, e_col, e_inf, e_oof);
                end
                if (last_idx == 5) begin
                    compared++;
                    if ((f == 1 && {o_oof, o_in_frame, o_row_cnt, o_col_cnt} !== {1'b1, 1'b0, 13'd0}) ||
                        (f == 2 && {o_oof, o_in_frame, o_row_cnt, o_col_cnt} !== {1'b0, 1'b0, 2'd0, 11'd5}) ||
                        (f == 3 && o_in_frame !== 1'b1)) begin
                        failed++;
                        $display("FAIL pre_check f%0d: got oof=%0b inf=%0b r=%0d c=%0d",
                                 f, o_oof, o_in_frame, o_row_cnt, o_col_cnt);
                    end
                end
            end
        end
        corrupt_pos = -1;
    endtask

    task automatic test_false_fas_and_reset();
        plant_pos = 2 * COLS + 300;
        for (int i = 0; i < FLEN + COLS + 501; i++) begin
            if (i == FLEN) plant_pos = -1;
            send_gen(1'b1);
            compared++;
            if (o_valid !== e_valid || o_sof !== e_sof || o_in_frame !== e_inf ||
                o_oof !== e_oof || o_row_cnt !== 2'(e_row) || o_col_cnt !== 11'(e_col)) begin
                failed++;
                $display("FAIL false_word i%0d: got r=%0d c=%0d inf=%0b need r=%0d c=%0d inf=%0b",
                         i, o_row_cnt, o_col_cnt, o_in_frame, e_row, e_col, e_inf);
            end
            if (i < FLEN && last_idx == 2 * COLS + 305) begin
                compared++;
                if ({o_row_cnt, o_col_cnt, o_in_frame} !== {2'd2, 11'd305, 1'b1}) begin
                    failed++;
                    $display("FAIL false_fas: got r=%0d c=%0d inf=%0b need 2 305 1",
                             o_row_cnt, o_col_cnt, o_in_frame);
                end
            end
        end
        compared++;
        if ({o_row_cnt, o_col_cnt} !== {2'd1, 11'd500}) begin
            failed++;
            $display("FAIL rst_point: got r=%0d c=%0d need 1 500", o_row_cnt, o_col_cnt);
        end
        do_reset();
        compared++;
        if ({o_valid, o_data, o_row_cnt, o_col_cnt, o_sof, o_in_frame, o_oof} !== {1'b0, 8'h00,
            2'd0, 11'd0, 1'b0, 1'b0, 1'b1}) begin
            failed++;
            $display("FAIL midframe_reset: got v=%0b d=%h r=%0d c=%0d sof=%0b inf=%0b oof=%0b",
                     o_valid, o_data, o_row_cnt, o_col_cnt, o_sof, o_in_frame, o_oof);
        end
        for (int i = 0; i < 20; i++) begin
            send_gen(1'b1);
            compared++;
            if (o_oof !== e_oof || o_in_frame !== e_inf || o_row_cnt !== 2'(e_row) ||
                o_col_cnt !== 11'(e_col)) begin
                failed++;
                $display("FAIL post_reset i%0d: got oof=%0b r=%0d c=%0d need oof=%0b r=%0d c=%0d",
                         i, o_oof, o_row_cnt, o_col_cnt, e_oof, e_row, e_col);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquire();
        test_valid_gaps();
        test_wrap();
        test_oof_thresh();
        test_presync_fail();
        test_false_fas_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
